uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 21 ++
 rtl/byte_fifo.sv | 79 +++++++
 rtl/uart_tx_fifo.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter with byte buffer.
// Holds the transmitter FSM state type, the line levels and the frame data width.
// Optional feature macro used by the design: UART_TX_PARITY_EN (even parity bit).
package uart_pkg;

    // Transmitter FSM states; PARITY is only reachable when parity is enabled
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with zero-latency head output (first-word fall-through).
// Ports:
//   CLK    in   clock, rising edge
//   RST_N  in   synchronous active-low reset; empties the buffer
//   push   in   write din at the tail (ignored when full)
//   din    in   byte to write
//   pop    in   drop the head entry (ignored when empty)
//   dout   out  current head byte, valid whenever empty is low
//   full   out  occupancy equals 2**DEPTH_LOG2
//   empty  out  occupancy equals zero
module byte_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] din,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] dout,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [DATA_BITS-1:0]  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at their width
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: a zero count makes old contents unreachable
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, or 8E1 with UART_TX_PARITY_EN defined) fed by a byte FIFO.
// Ports:
//   CLK    in   clock, rising edge
//   RST_N  in   synchronous active-low reset; aborts any frame in flight
//   data   in   byte to transmit
//   valid  in   data is presented; taken on an edge where valid && ready
//   ready  out  buffer can accept a byte this cycle (low while full or in reset)
//   TX     out  registered serial line, idle high
//   busy   out  registered; buffer non-empty or frame in progress
// Config macro: UART_TX_PARITY_EN adds an even parity bit between data and stop.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned DEPTH_LOG2  = 4
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 TX,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(CLK_PER_BIT);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    tx_state_t            state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 rst_done_q;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 bit_done;

    // ready stays low during reset; rst_done_q rises on the first edge after release
    assign ready     = rst_done_q && !fifo_full;
    assign fifo_push = valid && ready;
    assign bit_done  = (bit_cnt_q == CNT_MAX);
    assign TX        = tx_q;
    assign busy      = busy_q;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (fifo_push),
        .din   (data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Next-state, counters and FIFO pop
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_done ? '0 : bit_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^fifo_dout;
`endif
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next frame when more bytes are waiting
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^fifo_dout;
`endif
                        state_d  = START;
                    end else begin
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                bit_cnt_d = '0;
            end
        endcase
    end

    // Line level follows the current state, registered one cycle later
    always_comb begin
        tx_d = IDLE_LEVEL;
        case (state_q)
            START:   tx_d = START_LEVEL;
            DATA:    tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            STOP:    tx_d = STOP_LEVEL;
            default: tx_d = IDLE_LEVEL;
        endcase
        busy_d = (state_q != IDLE) || !fifo_empty;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            tx_q       <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            rst_done_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            rst_done_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted bytes are queued as expected frames,
// a serial-line monitor decodes TX and compares each received byte against the queue.
module tb_uart_tx_fifo;

    localparam int unsigned CPB = 4;
    localparam int unsigned DL2 = 2;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready;
    logic       TX;
    logic       busy;

    int unsigned cyc = 0;
    int unsigned errs = 0;
    int unsigned checks = 0;

    logic [7:0]  exp_q[$];
    int unsigned falls_q[$];

    uart_tx_fifo #(
        .CLK_PER_BIT (CPB),
        .DEPTH_LOG2  (DL2)
    ) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .data  (data),
        .valid (valid),
        .ready (ready),
        .TX    (TX),
        .busy  (busy)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cyc %0d", nm, got, exp, cyc);
        end
    endtask

    // Serial monitor: sample each bit mid-period on falling clock edges
    logic        in_frame = 1'b0;
    logic        prev = 1'b1;
    int unsigned off = 0;
    logic [7:0]  sh = 8'h00;

    initial begin
        forever begin
            @(negedge CLK);
            if (!RST_N) begin
                in_frame = 1'b0;
                prev     = 1'b1;
            end else if (!in_frame) begin
                if (prev && !TX) begin
                    in_frame = 1'b1;
                    off      = 0;
                    falls_q.push_back(cyc);
                end
                prev = TX;
            end else begin
                off++;
                if ((off % CPB) == CPB / 2) begin
                    int unsigned k;
                    k = off / CPB;
                    if (k == 0) begin
                        chk("start_bit", 32'(TX), 32'd0);
                    end else if (k <= 8) begin
                        sh[k-1] = TX;
                    end else if (k < NBITS - 1) begin
                        chk("parity_bit", 32'(TX), 32'(^sh));
                    end else begin
                        chk("stop_bit", 32'(TX), 32'd1);
                        if (exp_q.size() == 0) begin
                            checks++;
                            errs++;
                            $display("FAIL unexpected_frame: got byte 0x%0h expected none at cyc %0d", sh, cyc);
                        end else begin
                            chk("frame_byte", 32'(sh), 32'(exp_q.pop_front()));
                        end
                        in_frame = 1'b0;
                        prev     = TX;
                    end
                end
            end
        end
    end

    // Present a byte until accepted; valid is left high for the caller
    task automatic push_byte(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (ready) begin
                @(negedge CLK);
                exp_q.push_back(b);
                return;
            end
            @(negedge CLK);
        end
        chk("push_timeout", 32'(b), 32'hFFFF_FFFF);
    endtask

    task automatic wait_fall(input int unsigned n0, output int unsigned f);
        f = 0;
        for (int k = 0; k < 200; k++) begin
            if (falls_q.size() > n0) begin
                f = falls_q[n0];
                return;
            end
            @(negedge CLK);
        end
        chk("fall_timeout", 32'(falls_q.size()), 32'(n0 + 1));
    endtask

    task automatic wait_cyc(input int unsigned t);
        for (int k = 0; k < 400 && cyc < t; k++) @(negedge CLK);
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 600; k++) begin
            if (exp_q.size() == 0 && !busy) return;
            @(negedge CLK);
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish at cyc %0d", cyc);
        $fatal(1);
    end

    initial begin
        int unsigned n0;
        int unsigned f;
        int unsigned fx;
        logic [7:0] bl [6];
        bl[0] = 8'h11; bl[1] = 8'h22; bl[2] = 8'h33;
        bl[3] = 8'h44; bl[4] = 8'h5A; bl[5] = 8'h66;

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("rel_ready", 32'(ready), 32'd1);
        repeat (2) @(negedge CLK);

        // Single byte 0x55: busy high through the last frame cycle, low after
        n0 = falls_q.size();
        push_byte(8'h55);
        valid = 1'b0;
        wait_fall(n0, f);
        wait_cyc(f + FRAME - 1);
        chk("busy_last", 32'(busy), 32'd1);
        @(negedge CLK);
        chk("busy_drop", 32'(busy), 32'd0);
        chk("tx_idle", 32'(TX), 32'd1);
        wait_drain();

        // Two consecutive pushes: frames back to back
        n0 = falls_q.size();
        push_byte(8'hA3);
        push_byte(8'h0F);
        valid = 1'b0;
        wait_drain();
        chk("b2b_nframes", 32'(falls_q.size()), 32'(n0 + 2));
        if (falls_q.size() >= n0 + 2)
            chk("b2b_gap", 32'(falls_q[n0+1] - falls_q[n0]), 32'(FRAME));
        repeat (3) @(negedge CLK);

        // Fill while a frame is in flight, then hold valid against a full buffer
        n0 = falls_q.size();
        push_byte(8'hC3);
        for (int i = 0; i < 4; i++) push_byte(bl[i]);
        chk("ready_full", 32'(ready), 32'd0);
        data = bl[4];
        wait_fall(n0, fx);
        for (int k = 0; k < 200; k++) begin
            logic r;
            r = ready;
            chk("ready_hold", 32'(r), 32'(cyc == fx + FRAME - 1));
            if (r) begin
                @(negedge CLK);
                exp_q.push_back(bl[4]);
                chk("refull", 32'(ready), 32'd0);
                break;
            end
            @(negedge CLK);
        end
        push_byte(bl[5]);
        valid = 1'b0;
        wait_drain();
        chk("fill_nframes", 32'(falls_q.size()), 32'(n0 + 7));
        if (falls_q.size() >= n0 + 2)
            chk("fill_gap", 32'(falls_q[n0+1] - falls_q[n0]), 32'(FRAME));
        repeat (3) @(negedge CLK);

        // Reset during data bit 3 of 0xFF aborts the frame
        n0 = falls_q.size();
        push_byte(8'hFF);
        valid = 1'b0;
        wait_fall(n0, f);
        wait_cyc(f + 17);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("abort_tx", 32'(TX), 32'd1);
        chk("abort_ready", 32'(ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        chk("abort_rel_ready", 32'(ready), 32'd1);
        chk("abort_rel_busy", 32'(busy), 32'd0);
        repeat (60) @(negedge CLK);
        chk("abort_no_frame", 32'(falls_q.size()), 32'(n0 + 1));
        chk("abort_tx_idle", 32'(TX), 32'd1);

        // 0x07: last data bit low, frame length FRAME cycles
        n0 = falls_q.size();
        push_byte(8'h07);
        valid = 1'b0;
        wait_fall(n0, f);
        wait_cyc(f + 35);
        chk("b7_low", 32'(TX), 32'd0);
        wait_cyc(f + FRAME - 1);
        chk("len_busy_last", 32'(busy), 32'd1);
        chk("len_tx_stop", 32'(TX), 32'd1);
        @(negedge CLK);
        chk("len_busy_drop", 32'(busy), 32'd0);
        wait_drain();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
